// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide memory between a fetch requester (word
// reads) and a data requester (word reads/writes). Each request is granted
// in IDLE, moved as four big-endian byte beats in XFER and acknowledged with
// a one-cycle done pulse in DONE. Simultaneous requests alternate.
module mem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [31:0]       f_rdata,
    output logic              f_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte lane k of a word, big-endian (k = 0 is bits 31:24).
    function automatic logic [7:0] get_lane(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    get_lane = w[31:24];
            2'd1:    get_lane = w[23:16];
            2'd2:    get_lane = w[15:8];
            2'd3:    get_lane = w[7:0];
            default: get_lane = 8'h00;
        endcase
    endfunction

    // Replace byte lane k of a word, big-endian.
    function automatic logic [31:0] set_lane(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
        case (k)
            2'd0:    set_lane = {b, w[23:0]};
            2'd1:    set_lane = {w[31:24], b, w[15:0]};
            2'd2:    set_lane = {w[31:16], b, w[7:0]};
            2'd3:    set_lane = {w[31:8], b};
            default: set_lane = w;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic                gnt_data_q, gnt_data_d;   // 1 = data requester owns the transfer
    logic                last_data_q, last_data_d; // 1 = data was granted last time
    logic                we_q, we_d;
    logic [ADDR_W-1:2]   waddr_q, waddr_d;         // word address, low bits implicitly 00
    logic [31:0]         wdata_q, wdata_d;

    logic [31:0]         f_rdata_q, d_rdata_q;
    logic                f_done_q, f_done_d, d_done_q, d_done_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;

    // Byte-offset bits of the request addresses are discarded by word alignment.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[1:0], d_addr[1:0]};

    // State register plus the request context latched at grant time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b1;
            we_q        <= 1'b0;
            waddr_q     <= {(ADDR_W-2){1'b0}};
            wdata_q     <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Next state: arbitration and latching in IDLE, beat counting in XFER.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        we_d        = we_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                k_d = 2'd0;
                if (f_req || d_req) begin
                    state_d = XFER;
                    // Data wins when alone, or on a tie when fetch went last.
                    if (d_req && (!f_req || !last_data_q)) begin
                        gnt_data_d  = 1'b1;
                        last_data_d = 1'b1;
                        we_d        = d_we;
                        waddr_d     = d_addr[ADDR_W-1:2];
                        wdata_d     = d_wdata;
                    end else begin
                        gnt_data_d  = 1'b0;
                        last_data_d = 1'b0;
                        we_d        = 1'b0;
                        waddr_d     = f_addr[ADDR_W-1:2];
                        wdata_d     = wdata_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (k_q == 2'd3) begin
                    state_d = DONE;
                    k_d     = 2'd0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                k_d     = 2'd0;
            end
            default: begin
                state_d = IDLE;
                k_d     = 2'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so every port comes from a flop.
    always_comb begin
        mem_addr_d  = {ADDR_W{1'b0}};
        mem_we_d    = 1'b0;
        mem_wdata_d = 8'h00;
        f_done_d    = 1'b0;
        d_done_d    = 1'b0;
        if (state_d == XFER) begin
            mem_addr_d = {waddr_d, k_d};
            if (we_d) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = get_lane(wdata_d, k_d);
            end else begin
                mem_we_d    = 1'b0;
            end
        end else if (state_d == DONE) begin
            f_done_d = !gnt_data_d;
            d_done_d = gnt_data_d;
        end else begin
            mem_addr_d = {ADDR_W{1'b0}};
        end
    end

    // Output registers and read-data capture, one byte lane per XFER edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_rdata_q   <= 32'h0000_0000;
            d_rdata_q   <= 32'h0000_0000;
            f_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
        end else begin
            f_done_q    <= f_done_d;
            d_done_q    <= d_done_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            if (state_q == XFER && !we_q) begin
                if (gnt_data_q) begin
                    d_rdata_q <= set_lane(d_rdata_q, k_q, mem_rdata);
                end else begin
                    f_rdata_q <= set_lane(f_rdata_q, k_q, mem_rdata);
                end
            end
        end
    end

    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign f_done    = f_done_q;
    assign d_done    = d_done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte memory model drives mem_rdata, a transaction-
// level predictor is compared against every output each cycle, and directed
// scenarios pin the predictor with hand-computed values.
module tb_mem_arbiter;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          f_req, d_req, d_we;
    logic [AW-1:0] f_addr, d_addr;
    logic [31:0]   d_wdata, f_rdata, d_rdata;
    logic          f_done, d_done, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;

    logic [7:0] mem     [0:255];
    logic [7:0] mem_ref [0:255];

    int n_cmp  = 0;
    int n_fail = 0;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0: init_byte = 8'h0C;  1: init_byte = 8'h00;  2: init_byte = 8'h00;  3: init_byte = 8'h05;
            4: init_byte = 8'h00;  5: init_byte = 8'h00;  6: init_byte = 8'h00;  7: init_byte = 8'h28;
            8: init_byte = 8'h11;  9: init_byte = 8'h22; 10: init_byte = 8'h33; 11: init_byte = 8'h44;
            16: init_byte = 8'hDE; 17: init_byte = 8'hAD; 18: init_byte = 8'hBE; 19: init_byte = 8'hEF;
            default: init_byte = 8'(i) ^ 8'hA5;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory: preload, then byte writes on the rising edge.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    // Inputs as seen by the design at each rising edge.
    logic          s_rst = 1'b1;
    logic          s_freq = 1'b0, s_dreq = 1'b0, s_dwe = 1'b0;
    logic [AW-1:0] s_faddr = '0, s_daddr = '0;
    logic [31:0]   s_dwdata = '0;
    always @(posedge clk) begin
        s_rst    <= reset;
        s_freq   <= f_req;
        s_dreq   <= d_req;
        s_dwe    <= d_we;
        s_faddr  <= f_addr;
        s_daddr  <= d_addr;
        s_dwdata <= d_wdata;
    end

    // Transaction predictor: phase 0 idle, 1..4 byte beats, 5 done.
    int          p;
    bit          m_gd, m_last_d, m_we;
    int          m_addr;
    logic [31:0] m_wdata, m_frd, m_drd;

    task automatic model_reset();
        p = 0; m_gd = 1'b0; m_last_d = 1'b1; m_we = 1'b0;
        m_frd = 32'h0; m_drd = 32'h0;
    endtask

    task automatic model_step();
        int k;
        if (p == 0) begin
            if (s_freq || s_dreq) begin
                if (s_freq && s_dreq) m_gd = !m_last_d;
                else                  m_gd = s_dreq;
                m_last_d = m_gd;
                m_addr   = int'(m_gd ? s_daddr : s_faddr) / 4 * 4;
                m_we     = m_gd && s_dwe;
                m_wdata  = s_dwdata;
                p = 1;
            end
        end else if (p <= 4) begin
            k = p - 1;
            if (m_we) mem_ref[m_addr + k] = m_wdata[31 - 8*k -: 8];
            else if (m_gd) m_drd[31 - 8*k -: 8] = mem_ref[m_addr + k];
            else           m_frd[31 - 8*k -: 8] = mem_ref[m_addr + k];
            p = p + 1;
        end else begin
            p = 0;
        end
    endtask

    // Compare every output against the predictor on each falling edge.
    initial begin
        for (int i = 0; i < 256; i++) mem_ref[i] = init_byte(i);
        model_reset();
        forever begin
            @(negedge clk);
            if (s_rst) model_reset();
            else       model_step();
            if (reset) model_reset();
            chk("m_f_rdata",   f_rdata,   m_frd);
            chk("m_d_rdata",   d_rdata,   m_drd);
            chk("m_f_done",    {31'b0, f_done}, {31'b0, (p == 5) && !m_gd});
            chk("m_d_done",    {31'b0, d_done}, {31'b0, (p == 5) && m_gd});
            chk("m_mem_addr",  {24'b0, mem_addr}, (p >= 1 && p <= 4) ? 32'(m_addr + p - 1) : 32'h0);
            chk("m_mem_we",    {31'b0, mem_we}, {31'b0, (p >= 1 && p <= 4) && m_we});
            chk("m_mem_wdata", {24'b0, mem_wdata},
                ((p >= 1 && p <= 4) && m_we) ? {24'b0, m_wdata[31 - 8*(p-1) -: 8]} : 32'h0);
        end
    end

    task automatic wait_done(input bit want_d, output int edges, output int we_cycles);
        edges = 0; we_cycles = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (mem_we) we_cycles++;
            if (want_d ? d_done : f_done) begin
                edges = i;
                break;
            end
        end
        if (edges == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 30 edges");
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_f_rdata"}, f_rdata, 32'h0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
        chk({tag, "_dones"},   {30'b0, f_done, d_done}, 32'h0);
        chk({tag, "_mem_we"},  {31'b0, mem_we}, 32'h0);
        chk({tag, "_mem_addr"}, {24'b0, mem_addr}, 32'h0);
        chk({tag, "_mem_wdata"}, {24'b0, mem_wdata}, 32'h0);
    endtask

    initial begin
        int e, wc, n_done, fe, de;
        bit seen;
        logic [3:0] ord;
        reset = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = 8'h00; d_addr = 8'h00; d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Fetch of word 0.
        f_addr = 8'h00; f_req = 1'b1;
        wait_done(1'b0, e, wc);
        f_req = 1'b0;
        chk("fetch_latency", 32'(e), 32'd5);
        chk("fetch_rdata", f_rdata, 32'h0C00_0005);
        @(posedge clk); #1;
        chk("fetch_done_single", {31'b0, f_done}, 32'h0);

        // Data write to address 8.
        d_we = 1'b1; d_addr = 8'h08; d_wdata = 32'h0000_0028; d_req = 1'b1;
        wait_done(1'b1, e, wc);
        d_req = 1'b0; d_we = 1'b0;
        chk("write_latency", 32'(e), 32'd5);
        chk("write_we_cycles", 32'(wc), 32'd4);
        chk("write_keeps_d_rdata", d_rdata, 32'h0);
        @(posedge clk); #1;
        chk("write_mem", {mem[8], mem[9], mem[10], mem[11]}, 32'h0000_0028);

        // Unaligned data read.
        d_addr = 8'h07; d_req = 1'b1;
        wait_done(1'b1, e, wc);
        d_req = 1'b0;
        chk("unaligned_read", d_rdata, 32'h0000_0028);
        @(posedge clk); #1;

        // Tie after reset: fetch, data, fetch, data.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        f_addr = 8'h10; d_addr = 8'h04; d_we = 1'b0; f_req = 1'b1; d_req = 1'b1;
        n_done = 0; ord = 4'b0;
        for (int i = 0; i < 60 && n_done < 4; i++) begin
            @(posedge clk); #1;
            if (f_done) begin ord = {ord[2:0], 1'b0}; n_done++; end
            if (d_done) begin ord = {ord[2:0], 1'b1}; n_done++; end
        end
        f_req = 1'b0; d_req = 1'b0;
        chk("rr_count", 32'(n_done), 32'd4);
        chk("rr_order", {28'b0, ord}, 32'h5);
        chk("rr_f_rdata", f_rdata, 32'hDEAD_BEEF);
        chk("rr_d_rdata", d_rdata, 32'h0000_0028);
        @(posedge clk); #1;

        // Data request during a fetch transfer; fetch address moves mid-transfer.
        f_addr = 8'h10; f_req = 1'b1; fe = 0; de = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin
                d_addr = 8'h08; d_we = 1'b0; d_req = 1'b1; f_addr = 8'h20;
            end
            if (f_done && fe == 0) begin fe = i; f_req = 1'b0; end
            if (d_done && de == 0) begin de = i; d_req = 1'b0; end
            if (de != 0) break;
        end
        f_req = 1'b0; d_req = 1'b0;
        chk("wait_fetch_edge", 32'(fe), 32'd5);
        chk("wait_data_edge", 32'(de), 32'd11);
        chk("wait_f_rdata", f_rdata, 32'hDEAD_BEEF);
        chk("wait_d_rdata", d_rdata, 32'h0000_0028);
        @(posedge clk); #1;

        // Reset in the second beat of a write to word 0.
        d_we = 1'b1; d_addr = 8'h00; d_wdata = 32'hAABB_CCDD; d_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (f_done || d_done) seen = 1'b1;
        end
        chk("abort_no_done", {31'b0, seen}, 32'h0);
        chk("abort_byte0", {24'b0, mem[0]}, 32'hAA);
        chk("abort_byte2", {24'b0, mem[2]}, 32'h00);
        chk("abort_byte3", {24'b0, mem[3]}, 32'h05);

        for (int i = 0; i < 256; i++) chk("mem_image", {24'b0, mem[i]}, {24'b0, mem_ref[i]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
